// File: rtl/multi_polynomial_finder_pkg.sv
// rtl/multi_polynomial_finder_pkg.sv - shared states, default polynomials and LFSR step macro
`ifndef LFSR_STEP
// One Galois-style right-shift step; v must be a plain identifier so it can be bit-selected.
`define LFSR_STEP(v, p) (v[0] ? ((v >> 1) ^ (p)) : (v >> 1))
`endif

package lighthouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ESTIMATE,
    SEEK,
    WINDOW,
    DONE
  } state_t;

  localparam logic [16:0] POLY_1D258 = 17'h1d258;
  localparam logic [16:0] POLY_17E04 = 17'h17e04;

  // A single candidate still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_polynomial_finder_if.sv
// rtl/multi_polynomial_finder_if.sv - request/result bundle of the finder (AMBIGUITY_DETECT_EN adds ambiguous)
interface multi_polynomial_finder_if
  import lighthouse_pkg::*;
#(
  parameter int NUM_POLY = 2,
  parameter int LFSR_W   = 17,
  parameter int TS_W     = 24,
  parameter int IDX_W    = idx_width(NUM_POLY)
);

  logic              start;
  logic              abort;
  logic [TS_W-1:0]   ts_start;
  logic [TS_W-1:0]   ts_end;
  logic [LFSR_W-1:0] data_start;
  logic [LFSR_W-1:0] data_end;
  logic              ready;
  logic              done;
  logic              found;
  logic              error;
  logic [IDX_W-1:0]  poly_index;
  logic [LFSR_W-1:0] polynomial;
  logic [LFSR_W-1:0] iteration_number;
`ifdef AMBIGUITY_DETECT_EN
  logic              ambiguous;

  modport master (
    output start, abort, ts_start, ts_end, data_start, data_end,
    input  ready, done, found, error, poly_index, polynomial, iteration_number, ambiguous
  );

  modport slave (
    input  start, abort, ts_start, ts_end, data_start, data_end,
    output ready, done, found, error, poly_index, polynomial, iteration_number, ambiguous
  );
`else
  modport master (
    output start, abort, ts_start, ts_end, data_start, data_end,
    input  ready, done, found, error, poly_index, polynomial, iteration_number
  );

  modport slave (
    input  start, abort, ts_start, ts_end, data_start, data_end,
    output ready, done, found, error, poly_index, polynomial, iteration_number
  );
`endif

endinterface

// File: rtl/multi_polynomial_finder_lfsr_lane.sv
// rtl/multi_polynomial_finder_lfsr_lane.sv - one candidate LFSR register with load/step control
module lfsr_lane #(
  parameter int LFSR_W = 17
) (
  input  logic              clk_72MHz,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  input  logic [LFSR_W-1:0] polynomial,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] r_value;

  // Seeded before every search, so it carries no reset of its own.
  always_ff @(posedge clk_72MHz) begin
    if (load) begin
      r_value <= seed;
    end else if (step) begin
      r_value <= `LFSR_STEP(r_value, polynomial);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/multi_polynomial_finder.sv
// rtl/multi_polynomial_finder.sv - finds which LFSR polynomial links two beacon words (AMBIGUITY_DETECT_EN)
module multi_polynomial_finder
  import lighthouse_pkg::*;
#(
  parameter int NUM_POLY = 2,
  parameter int LFSR_W   = 17,
  parameter int TS_W     = 24,
  parameter int TS_SHIFT = 4,
  parameter int ITER_TOL = 2,
  parameter logic [NUM_POLY*LFSR_W-1:0] POLYS = {POLY_17E04, POLY_1D258}
) (
  input logic                      clk_72MHz,
  input logic                      reset,
  multi_polynomial_finder_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_POLY);
  localparam logic [LFSR_W-1:0] TOL = LFSR_W'(ITER_TOL);

  state_t            r_state;
  state_t            w_next;

  logic [TS_W-1:0]   r_ts_start;
  logic [TS_W-1:0]   r_ts_end;
  logic [LFSR_W-1:0] r_data_start;
  logic [LFSR_W-1:0] r_data_end;
  logic [LFSR_W-1:0] r_k;
  logic [LFSR_W-1:0] r_lo;
  logic [LFSR_W-1:0] r_hi;

  logic              r_found;
  logic              r_error;
  logic [IDX_W-1:0]  r_idx;
  logic [LFSR_W-1:0] r_poly;
  logic [LFSR_W-1:0] r_iter;
`ifdef AMBIGUITY_DETECT_EN
  logic              r_ambiguous;
`endif

  logic [TS_W-1:0]   w_delta;
  logic [LFSR_W-1:0] w_est;
  logic [LFSR_W-1:0] w_lo;
  logic [LFSR_W:0]   w_hi_sum;
  logic [LFSR_W-1:0] w_hi;
  logic [LFSR_W-1:0] w_k_inc;
  logic              w_degen;
  logic              w_running;
  logic              w_abort_now;
  logic              w_accept;
  logic              w_load;
  logic              w_step;

  logic [LFSR_W-1:0] w_value [NUM_POLY];
  logic [NUM_POLY-1:0] w_hit;
  logic              w_any_hit;
  logic [IDX_W-1:0]  w_hit_idx;
  logic [LFSR_W-1:0] w_hit_poly;

  // Step-count estimate and tolerance window; unsigned subtraction gives the exact wrap.
  assign w_delta  = r_ts_end - r_ts_start;
  assign w_est    = LFSR_W'(w_delta >> TS_SHIFT);
  assign w_lo     = (w_est < TOL) ? '0 : (w_est - TOL);
  assign w_hi_sum = {1'b0, w_est} + {1'b0, TOL};
  assign w_hi     = w_hi_sum[LFSR_W] ? '1 : w_hi_sum[LFSR_W-1:0];
  assign w_k_inc  = r_k + LFSR_W'(1);

  assign w_degen     = (r_data_start == r_data_end) || (r_ts_start == r_ts_end);
  assign w_running   = (r_state == ESTIMATE) || (r_state == SEEK) || (r_state == WINDOW);
  assign w_abort_now = bus.abort && w_running;
  assign w_accept    = (r_state == IDLE) && bus.start;

  for (genvar g = 0; g < NUM_POLY; g++) begin : g_lane
    lfsr_lane #(
      .LFSR_W(LFSR_W)
    ) u_lane (
      .clk_72MHz (clk_72MHz),
      .load      (w_load),
      .step      (w_step),
      .seed      (r_data_start),
      .polynomial(POLYS[g*LFSR_W +: LFSR_W]),
      .value     (w_value[g])
    );
  end

  // Compare every lane with the target; descending scan leaves the lowest matching lane.
  always_comb begin
    w_hit      = '0;
    w_any_hit  = 1'b0;
    w_hit_idx  = '0;
    w_hit_poly = '0;
    for (int i = NUM_POLY - 1; i >= 0; i--) begin
      w_hit[i] = (w_value[i] == r_data_end);
      if (w_hit[i]) begin
        w_any_hit  = 1'b1;
        w_hit_idx  = IDX_W'(i);
        w_hit_poly = POLYS[i*LFSR_W +: LFSR_W];
      end
    end
  end

  // Next-state and lane control; abort always takes priority over a match.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = ESTIMATE;
      end
      ESTIMATE: begin
        if (bus.abort || w_degen) begin
          w_next = DONE;
        end else begin
          w_load = 1'b1;
          w_next = (w_lo == '0) ? WINDOW : SEEK;
        end
      end
      SEEK: begin
        if (bus.abort) begin
          w_next = DONE;
        end else begin
          w_step = 1'b1;
          if (w_k_inc == r_lo) w_next = WINDOW;
        end
      end
      WINDOW: begin
        if (bus.abort) begin
          w_next = DONE;
`ifdef AMBIGUITY_DETECT_EN
        end else if (r_k == r_hi) begin
`else
        end else if (w_any_hit || (r_k == r_hi)) begin
`endif
          w_next = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch, step counter and window bounds.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      r_ts_start   <= '0;
      r_ts_end     <= '0;
      r_data_start <= '0;
      r_data_end   <= '0;
      r_k          <= '0;
      r_lo         <= '0;
      r_hi         <= '0;
    end else begin
      if (w_accept) begin
        r_ts_start   <= bus.ts_start;
        r_ts_end     <= bus.ts_end;
        r_data_start <= bus.data_start;
        r_data_end   <= bus.data_end;
      end
      if (r_state == ESTIMATE) begin
        r_k  <= '0;
        r_lo <= w_lo;
        r_hi <= w_hi;
      end else if (w_step) begin
        r_k <= w_k_inc;
      end
    end
  end

  // Result registers: cleared on an accepted start, held from done until the next one.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      r_found     <= 1'b0;
      r_error     <= 1'b0;
      r_idx       <= '0;
      r_poly      <= '0;
      r_iter      <= '0;
`ifdef AMBIGUITY_DETECT_EN
      r_ambiguous <= 1'b0;
`endif
    end else if (w_accept || w_abort_now) begin
      r_found     <= 1'b0;
      r_error     <= w_abort_now;
      r_idx       <= '0;
      r_poly      <= '0;
      r_iter      <= '0;
`ifdef AMBIGUITY_DETECT_EN
      r_ambiguous <= 1'b0;
`endif
    end else if ((r_state == ESTIMATE) && w_degen) begin
      r_error <= 1'b1;
    end else if ((r_state == WINDOW) && w_any_hit) begin
      if (!r_found) begin
        r_found <= 1'b1;
        r_idx   <= w_hit_idx;
        r_poly  <= w_hit_poly;
        r_iter  <= r_k;
      end
`ifdef AMBIGUITY_DETECT_EN
      if (r_found || ($countones(w_hit) > 1)) r_ambiguous <= 1'b1;
`endif
    end
  end

  assign bus.ready            = (r_state == IDLE);
  assign bus.done             = (r_state == DONE);
  assign bus.found            = r_found;
  assign bus.error            = r_error;
  assign bus.poly_index       = r_idx;
  assign bus.polynomial       = r_poly;
  assign bus.iteration_number = r_iter;
`ifdef AMBIGUITY_DETECT_EN
  assign bus.ambiguous        = r_ambiguous;
`endif

endmodule

// File: tb/tb_multi_polynomial_finder.sv
// tb/tb_multi_polynomial_finder.sv - scoreboard bench for multi_polynomial_finder (default build)
module tb_multi_polynomial_finder;

  localparam int NUM_POLY = 2;
  localparam int LFSR_W   = 17;
  localparam int TS_W     = 24;

  typedef struct {
    logic        found;
    logic        error;
    logic        idx;
    logic [16:0] poly;
    logic [16:0] iter;
    int          lat;
  } exp_t;

  logic clk_72MHz = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk_72MHz = ~clk_72MHz;

  multi_polynomial_finder_if #(.NUM_POLY(NUM_POLY), .LFSR_W(LFSR_W), .TS_W(TS_W)) bus ();

  multi_polynomial_finder #(
    .NUM_POLY(NUM_POLY),
    .LFSR_W  (LFSR_W),
    .TS_W    (TS_W),
    .TS_SHIFT(4),
    .ITER_TOL(2),
    .POLYS   ({17'h17e04, 17'h1d258})
  ) dut (
    .clk_72MHz(clk_72MHz),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] poly_of(input int lane);
    return (lane == 0) ? 17'h1d258 : 17'h17e04;
  endfunction

  function automatic logic [16:0] advance(input logic [16:0] v, input int lane, input int n);
    logic [16:0] x;
    x = v;
    for (int s = 0; s < n; s++) x = x[0] ? ((x >> 1) ^ poly_of(lane)) : (x >> 1);
    return x;
  endfunction

  // Reference search: walk k from 0, compare inside [lo,hi], lowest k then lowest lane.
  function automatic exp_t model(input logic [23:0] tss, input logic [23:0] tse,
                                 input logic [16:0] ds, input logic [16:0] de);
    exp_t        e;
    logic [23:0] delta;
    logic [16:0] est, lo, hi;
    logic [17:0] hsum;
    logic [16:0] v [2];
    e = '{default: 0};
    if (ds == de || tss == tse) begin
      e.error = 1'b1;
      e.lat   = 2;
      return e;
    end
    delta = tse - tss;
    est   = 17'(delta >> 4);
    lo    = (est < 17'd2) ? 17'd0 : est - 17'd2;
    hsum  = {1'b0, est} + 18'd2;
    hi    = hsum[17] ? 17'h1ffff : hsum[16:0];
    v[0]  = ds;
    v[1]  = ds;
    for (int k = 0; k <= int'(hi); k++) begin
      if (k >= int'(lo)) begin
        for (int i = 0; i < 2; i++) begin
          if (v[i] == de && !e.found) begin
            e.found = 1'b1;
            e.idx   = i[0];
            e.poly  = poly_of(i);
            e.iter  = 17'(k);
          end
        end
        if (e.found || k == int'(hi)) begin
          e.lat = k + 3;
          return e;
        end
      end
      for (int i = 0; i < 2; i++) v[i] = advance(v[i], i, 1);
    end
    return e;
  endfunction

  task automatic score(input string tag, input int cyc);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, cyc, e.lat);
    check({tag, "_found"}, bus.found, e.found);
    check({tag, "_error"}, bus.error, e.error);
    check({tag, "_index"}, bus.poly_index, e.idx);
    check({tag, "_poly"}, bus.polynomial, e.poly);
    if (e.found) check({tag, "_iter"}, bus.iteration_number, e.iter);
    @(negedge clk_72MHz);
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_ready_after"}, bus.ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [23:0] tss, input logic [23:0] tse,
                     input logic [16:0] ds, input logic [16:0] de,
                     input bit poke, input int abort_at);
    exp_t e;
    bit   seen;
    e = model(tss, tse, ds, de);
    if (abort_at > 0) begin
      e       = '{default: 0};
      e.error = 1'b1;
      e.lat   = abort_at + 1;
    end
    sb.push_back(e);
    bus.ts_start   = tss;
    bus.ts_end     = tse;
    bus.data_start = ds;
    bus.data_end   = de;
    bus.start      = 1'b1;
    seen           = 1'b0;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      @(negedge clk_72MHz);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (cyc == 1) check({tag, "_ready_low"}, bus.ready, 1'b0);
      if (bus.done) begin
        seen = 1'b1;
        score(tag, cyc);
      end else begin
        if (poke && (cyc % 3 == 0)) bus.start = 1'b1;
        if (cyc == abort_at) bus.abort = 1'b1;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    bit saw_done;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.ts_start   = '0;
    bus.ts_end     = '0;
    bus.data_start = '0;
    bus.data_end   = '0;
    repeat (2) @(negedge clk_72MHz);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_found", bus.found, 1'b0);
    check("rst_error", bus.error, 1'b0);
    check("rst_index", bus.poly_index, 1'b0);
    check("rst_poly", bus.polynomial, 17'h0);
    check("rst_iter", bus.iteration_number, 17'h0);
    reset = 1'b0;
    @(negedge clk_72MHz);

    run("lane0", 24'h000100, 24'h000120, 17'h00001, 17'h0e92c, 1'b0, 0);
    check("lane0_const_found", bus.found, 1'b1);
    check("lane0_const_poly", bus.polynomial, 17'h1d258);
    check("lane0_const_iter", bus.iteration_number, 17'd2);

    run("lane1", 24'h000100, 24'h000120, 17'h00001, 17'h0bf02, 1'b0, 0);
    check("lane1_const_index", bus.poly_index, 1'b1);
    check("lane1_const_poly", bus.polynomial, 17'h17e04);
    check("lane1_const_iter", bus.iteration_number, 17'd2);

    run("wrap", 24'hfffff0, 24'h000010, 17'h00001, 17'h0e92c, 1'b0, 0);
    check("wrap_const_iter", bus.iteration_number, 17'd2);

    run("degen_ts", 24'h000500, 24'h000500, 17'h00001, 17'h0e92c, 1'b0, 0);
    check("degen_const_error", bus.error, 1'b1);
    check("degen_const_poly", bus.polynomial, 17'h0);

    run("degen_data", 24'h000100, 24'h000120, 17'h0abcd, 17'h0abcd, 1'b0, 0);

    run("nomatch", 24'h000100, 24'h000380, 17'h00001, 17'h12345, 1'b1, 0);
    check("nomatch_const_found", bus.found, 1'b0);
    check("nomatch_const_error", bus.error, 1'b0);

    for (int n = 0; n < 8; n++) begin
      logic [16:0] ds, de;
      logic [23:0] tss, delta;
      int          ln, j, off, e_steps;
      ds      = 17'($urandom_range(1, 17'h1ffff));
      ln      = $urandom_range(0, 1);
      j       = $urandom_range(0, 20);
      off     = $urandom_range(0, 6) - 3;
      e_steps = (j + off < 0) ? 0 : j + off;
      de      = advance(ds, ln, j);
      delta   = 24'(e_steps * 16 + $urandom_range(0, 15));
      tss     = 24'($urandom);
      run("rand", tss, tss + delta, ds, de, 1'b0, 0);
    end

    run("abort", 24'h000100, 24'h000380, 17'h00001, 17'h12345, 1'b0, 12);
    check("abort_const_error", bus.error, 1'b1);

    bus.ts_start   = 24'h000100;
    bus.ts_end     = 24'h000380;
    bus.data_start = 17'h00001;
    bus.data_end   = 17'h12345;
    bus.start      = 1'b1;
    @(negedge clk_72MHz);
    bus.start = 1'b0;
    repeat (5) @(negedge clk_72MHz);
    reset = 1'b1;
    @(negedge clk_72MHz);
    reset = 1'b0;
    check("midrst_ready", bus.ready, 1'b1);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_error", bus.error, 1'b0);
    check("midrst_found", bus.found, 1'b0);
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk_72MHz);
      if (bus.done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);

    run("recover", 24'h000100, 24'h000120, 17'h00001, 17'h0e92c, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk_72MHz);
    reset = 1'b0;
    check("idlerst_found", bus.found, 1'b0);
    check("idlerst_poly", bus.polynomial, 17'h0);
    check("idlerst_iter", bus.iteration_number, 17'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
